// File: rtl/muldiv_seq_ctrl.sv
// Iterative RV32M sequencer: 32-step shift-add multiply and restoring divide.
// Divide-by-zero and signed overflow take a fast path that skips the iteration.
module muldiv_seq_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic [6:0]      f7_i,
   input  logic [2:0]      f3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            ready_o,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

   state_t            state, state_nx;
   logic [2:0]        op;
   logic [XLEN-1:0]   a, b, ma, mb;
   logic              neg;
   logic [2*XLEN-1:0] acc;
   logic [CW-1:0]     cnt;

   logic              claim, accept;
   logic              sa_on, sb_on, sgn_a, sgn_b;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic              div_zero, ovf, fast;
   logic [XLEN-1:0]   fast_val;
   logic [CW-1:0]     didx;
   logic [XLEN:0]     sum, rem_sh, diff;
   logic [2*XLEN-1:0] acc_mul, acc_div, prod_n;
   logic [XLEN-1:0]   raw, fix_val;
   logic              last;

   assign claim  = valid_i && (f7_i == 7'h01);
   assign accept = (state == IDLE) && claim;

   assign sa_on = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
   assign sb_on = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
   assign sgn_a = sa_on && a[XLEN-1];
   assign sgn_b = sb_on && b[XLEN-1];
   assign abs_a = sgn_a ? (~a + 1'b1) : a;
   assign abs_b = sgn_b ? (~b + 1'b1) : b;

   assign div_zero = op[2] && (b == '0);
   assign ovf      = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   assign fast     = div_zero || ovf;
   assign fast_val = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

   // Multiply consumes multiplier bits LSB first; divide feeds dividend MSB first.
   assign didx    = CW'(XLEN-1) - cnt;
   assign sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (mb[cnt] ? {1'b0, ma} : '0);
   assign acc_mul = {sum, acc[XLEN-1:1]};
   assign rem_sh  = {acc[2*XLEN-1:XLEN], ma[didx]};
   assign diff    = rem_sh - {1'b0, mb};
   assign acc_div = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   assign last    = (cnt == CW'(XLEN-1));

   assign prod_n = neg ? (~acc + 1'b1) : acc;
   assign raw    = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];

   always_comb begin
      fix_val = '0;
      if (op[2])
         fix_val = neg ? (~raw + 1'b1) : raw;
      else if (op[1:0] == 2'd0)
         fix_val = prod_n[XLEN-1:0];
      else
         fix_val = prod_n[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_nx = state;
      ready_o  = 1'b0;
      stall_o  = 1'b0;
      done_o   = 1'b0;
      unique case (state)
         IDLE: begin
            ready_o = 1'b1;
            stall_o = claim;
            if (accept) state_nx = PREP;
         end
         PREP: begin
            stall_o = 1'b1;
            if (flush_i)   state_nx = IDLE;
            else if (fast) state_nx = DONE;
            else           state_nx = CALC;
         end
         CALC: begin
            stall_o = 1'b1;
            if (flush_i)   state_nx = IDLE;
            else if (last) state_nx = FIX;
         end
         FIX: begin
            stall_o  = 1'b1;
            state_nx = flush_i ? IDLE : DONE;
         end
         DONE: begin
            done_o   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         op       <= '0;
         a        <= '0;
         b        <= '0;
         ma       <= '0;
         mb       <= '0;
         neg      <= 1'b0;
         acc      <= '0;
         cnt      <= '0;
         result_o <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (accept) begin
                  op <= f3_i;
                  a  <= rs1_i;
                  b  <= rs2_i;
               end
            end
            PREP: begin
               ma  <= abs_a;
               mb  <= abs_b;
               // Remainder follows the dividend; everything else is sign XOR.
               neg <= (op[2] && op[1]) ? sgn_a : (sgn_a ^ sgn_b);
               acc <= '0;
               cnt <= '0;
               if (fast && !flush_i) result_o <= fast_val;
            end
            CALC: begin
               acc <= op[2] ? acc_div : acc_mul;
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               if (!flush_i) result_o <= fix_val;
            end
            default: ;
         endcase
      end
   end

endmodule
